// File: rtl/anaio_mux_ctrl.sv
// -----------------------------------------------------------------------------
// anaio_mux_ctrl
//
// Break-before-make sequencer for the analog switch matrix in front of the
// analog I/O pad. One of N_SRC internal analog nodes is routed onto the pad
// net. Every change of connection first opens all switches for BBM_CYC
// cycles. A newly made connection is then given SETTLE_CYC cycles before
// pad_ready_o declares the pad voltage trustworthy. All outputs come straight
// from flops, so the switch enables cannot glitch.
//
// Optional feature macro: ANAIO_MUX_RANGE_CHK_EN
//   defined   : an out-of-range connect is treated as a disconnect and sets the
//               sticky err_o flag.
//   undefined : an out-of-range connect is accepted and discarded; there is no
//               err_o port.
//
// Ports
//   clk_i        block clock
//   rst_i        synchronous, active-high reset
//   req_valid_i  request valid
//   req_ready_o  request can be accepted this cycle (IDLE / CONN)
//   req_conn_i   1 = connect req_sel_i, 0 = disconnect all
//   req_sel_i    source index
//   sw_en_o      switch enables, one-hot or all-zero
//   sel_o        connected / connecting source, 0 when idle
//   pad_ready_o  connected source has settled
//   busy_o       break or make sequence in progress
//   err_o        sticky range error (ANAIO_MUX_RANGE_CHK_EN only)
// -----------------------------------------------------------------------------
module anaio_mux_ctrl #(
    parameter int  N_SRC      = 8,
    parameter int  BBM_CYC    = 4,
    parameter int  SETTLE_CYC = 16,
    localparam int SEL_W      = $clog2(N_SRC)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_conn_i,
    input  logic [SEL_W-1:0] req_sel_i,
    output logic [N_SRC-1:0] sw_en_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             pad_ready_o,
    output logic             busy_o
`ifdef ANAIO_MUX_RANGE_CHK_EN
    ,
    output logic             err_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_CONN  = 2'd3
    } state_e;

    // Counters count down to zero, so the loaded value is one less than the
    // number of cycles spent in the phase.
    localparam logic [15:0]      BBM_LOAD    = 16'(BBM_CYC - 1);
    localparam logic [15:0]      SETTLE_LOAD = 16'(SETTLE_CYC - 1);
    localparam logic [N_SRC-1:0] ONE_HOT_LSB = {{(N_SRC-1){1'b0}}, 1'b1};
    localparam logic [4:0]       N_SRC_W     = 5'(N_SRC);

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_SRC-1:0] sw_en_q, sw_en_d;
    logic             pad_ready_q, pad_ready_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;
    // Remembers whether the running break period ends in MAKE or in IDLE.
    logic             make_pend_q, make_pend_d;
`ifdef ANAIO_MUX_RANGE_CHK_EN
    logic             err_q, err_d;
    logic             range_err_s;
`endif

    logic accept_s;
    logic sel_ok_s;
    logic start_conn_s;
    logic start_disc_s;

    assign accept_s = req_valid_i & req_ready_q;
    assign sel_ok_s = (5'(req_sel_i) < N_SRC_W);

    // Request decode: classify an accepted request as connect or disconnect.
    always_comb begin
        start_conn_s = 1'b0;
        start_disc_s = 1'b0;
`ifdef ANAIO_MUX_RANGE_CHK_EN
        range_err_s  = 1'b0;
`endif
        if (accept_s) begin
            if (req_conn_i) begin
                if (sel_ok_s) begin
                    // Reconnecting the source that is already settled is a no-op.
                    if ((state_q == ST_CONN) && (req_sel_i == sel_q)) begin
                        start_conn_s = 1'b0;
                    end else begin
                        start_conn_s = 1'b1;
                    end
                end else begin
`ifdef ANAIO_MUX_RANGE_CHK_EN
                    range_err_s  = 1'b1;
                    start_disc_s = (state_q == ST_CONN);
`else
                    start_conn_s = 1'b0;
`endif
                end
            end else begin
                // Disconnect while idle is a no-op.
                start_disc_s = (state_q == ST_CONN);
            end
        end else begin
            start_conn_s = 1'b0;
        end
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        sw_en_d     = sw_en_q;
        pad_ready_d = pad_ready_q;
        busy_d      = busy_q;
        req_ready_d = req_ready_q;
        make_pend_d = make_pend_q;
`ifdef ANAIO_MUX_RANGE_CHK_EN
        err_d       = err_q | range_err_s;
`endif
        case (state_q)
            ST_IDLE, ST_CONN: begin
                if (start_conn_s || start_disc_s) begin
                    // Both paths open every switch first; only a connect
                    // continues into MAKE afterwards.
                    state_d     = ST_BREAK;
                    cnt_d       = BBM_LOAD;
                    sw_en_d     = {N_SRC{1'b0}};
                    pad_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    req_ready_d = 1'b0;
                    make_pend_d = start_conn_s;
                    if (start_conn_s) begin
                        sel_d = req_sel_i;
                    end else begin
                        // sel_o keeps naming the old source until IDLE.
                        sel_d = sel_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_BREAK: begin
                if (cnt_q == 16'd0) begin
                    if (make_pend_q) begin
                        state_d = ST_MAKE;
                        cnt_d   = SETTLE_LOAD;
                        sw_en_d = ONE_HOT_LSB << sel_q;
                    end else begin
                        state_d     = ST_IDLE;
                        sel_d       = {SEL_W{1'b0}};
                        busy_d      = 1'b0;
                        req_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_MAKE: begin
                if (cnt_q == 16'd0) begin
                    state_d     = ST_CONN;
                    pad_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                // Unreachable encoding: fall back to the safe, all-open state.
                state_d     = ST_IDLE;
                cnt_d       = 16'd0;
                sel_d       = {SEL_W{1'b0}};
                sw_en_d     = {N_SRC{1'b0}};
                pad_ready_d = 1'b0;
                busy_d      = 1'b0;
                req_ready_d = 1'b1;
                make_pend_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset opens all switches immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            sel_q       <= {SEL_W{1'b0}};
            sw_en_q     <= {N_SRC{1'b0}};
            pad_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            make_pend_q <= 1'b0;
`ifdef ANAIO_MUX_RANGE_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sw_en_q     <= sw_en_d;
            pad_ready_q <= pad_ready_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            make_pend_q <= make_pend_d;
`ifdef ANAIO_MUX_RANGE_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign sw_en_o     = sw_en_q;
    assign sel_o       = sel_q;
    assign pad_ready_o = pad_ready_q;
    assign busy_o      = busy_q;
`ifdef ANAIO_MUX_RANGE_CHK_EN
    assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_anaio_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_anaio_mux_ctrl
//
// Self-checking bench for anaio_mux_ctrl (N_SRC=6 so that selector codes 6
// and 7 are out of range). The reference model is a timeline: it records the
// cycle on which a request was accepted and derives every output from the
// elapsed cycle count against BBM_CYC and SETTLE_CYC.
// -----------------------------------------------------------------------------
module tb_anaio_mux_ctrl;

    localparam int N_SRC  = 6;
    localparam int BBM    = 4;
    localparam int SETTLE = 16;
    localparam int SEL_W  = 3;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_conn_i;
    logic [SEL_W-1:0] req_sel_i;
    logic [N_SRC-1:0] sw_en_o;
    logic [SEL_W-1:0] sel_o;
    logic             pad_ready_o;
    logic             busy_o;
`ifdef ANAIO_MUX_RANGE_CHK_EN
    logic             err_o;
`endif

    always #5 clk_i = ~clk_i;

    anaio_mux_ctrl #(
        .N_SRC      (N_SRC),
        .BBM_CYC    (BBM),
        .SETTLE_CYC (SETTLE)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_conn_i  (req_conn_i),
        .req_sel_i   (req_sel_i),
        .sw_en_o     (sw_en_o),
        .sel_o       (sel_o),
        .pad_ready_o (pad_ready_o),
        .busy_o      (busy_o)
`ifdef ANAIO_MUX_RANGE_CHK_EN
        ,
        .err_o       (err_o)
`endif
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // Reference model: settled source (-1 = none), pending transition.
    int m_cur = -1;
    int m_tgt = 0;
    int m_acc = -1;
    bit m_conn_tr = 1'b0;
    bit m_err = 1'b0;

    logic [N_SRC-1:0] e_sw;
    int               e_sel;
    bit               e_pad;
    bit               e_busy;
    bit               e_ready = 1'b1;
    bit               e_err;
    logic [N_SRC-1:0] prev_sw = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model across one clock edge using the inputs of the
    // cycle that just ended.
    task automatic model_edge();
        int el;
        int s;
        el = 0;
        cyc++;
        if (rst_i) begin
            m_cur = -1;
            m_acc = -1;
            m_err = 1'b0;
        end else if (req_valid_i && e_ready) begin
            s = int'(req_sel_i);
            if (req_conn_i && s < N_SRC) begin
                if (m_cur != s) begin
                    m_tgt     = s;
                    m_acc     = cyc - 1;
                    m_conn_tr = 1'b1;
                end
            end else if (req_conn_i) begin
`ifdef ANAIO_MUX_RANGE_CHK_EN
                m_err = 1'b1;
                if (m_cur >= 0) begin
                    m_acc     = cyc - 1;
                    m_conn_tr = 1'b0;
                end
`endif
            end else if (m_cur >= 0) begin
                m_acc     = cyc - 1;
                m_conn_tr = 1'b0;
            end
        end
        if (m_acc >= 0) begin
            el = cyc - m_acc;
            if (m_conn_tr && el > BBM + SETTLE) begin
                m_cur = m_tgt;
                m_acc = -1;
            end else if (!m_conn_tr && el > BBM) begin
                m_cur = -1;
                m_acc = -1;
            end
        end
        e_sw = '0; e_sel = 0; e_pad = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
        if (m_acc >= 0) begin
            e_busy  = 1'b1;
            e_ready = 1'b0;
            if (m_conn_tr) begin
                e_sel = m_tgt;
                if (el > BBM) e_sw[m_tgt] = 1'b1;
            end else begin
                e_sel = m_cur;
            end
        end else if (m_cur >= 0) begin
            e_sel        = m_cur;
            e_sw[m_cur]  = 1'b1;
            e_pad        = 1'b1;
        end
        e_err = m_err;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("sw_en", 32'(sw_en_o), 32'(e_sw));
        chk("sel", 32'(sel_o), e_sel);
        chk("pad_ready", 32'(pad_ready_o), 32'(e_pad));
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("req_ready", 32'(req_ready_o), 32'(e_ready));
`ifdef ANAIO_MUX_RANGE_CHK_EN
        chk("err", 32'(err_o), 32'(e_err));
`endif
        chk("onehot", 32'($countones(sw_en_o) <= 1), 32'd1);
        chk("bbm_gap", 32'(prev_sw != '0 && sw_en_o != '0 && prev_sw != sw_en_o), 32'd0);
        prev_sw = sw_en_o;
    endtask

    task automatic req(input bit conn, input int sel);
        req_valid_i = 1'b1;
        req_conn_i  = conn;
        req_sel_i   = SEL_W'(sel);
        step();
        req_valid_i = 1'b0;
    endtask

    // Called right after the accepting edge (cycle 1); returns the cycle
    // numbers of the first one-hot value and of pad_ready rising.
    task automatic measure(output int lat_sw, output int lat_pad);
        lat_sw  = 0;
        lat_pad = 0;
        for (int i = 2; i <= 60; i++) begin
            step();
            if (lat_sw == 0 && sw_en_o != '0) lat_sw = i;
            if (pad_ready_o) begin
                lat_pad = i;
                break;
            end
        end
    endtask

    initial begin
        int lat_sw;
        int lat_pad;
        int n;
        rst_i = 1'b1; req_valid_i = 1'b0; req_conn_i = 1'b0; req_sel_i = '0;
        step(); step();
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_sw", 32'(sw_en_o), 32'd0);
        rst_i = 1'b0;
        step();

        // Connect 3 from idle.
        req(1'b1, 3);
        chk("c3_ready_low", 32'(req_ready_o), 32'd0);
        measure(lat_sw, lat_pad);
        chk("c3_lat_sw", lat_sw, 5);
        chk("c3_lat_pad", lat_pad, 21);
        chk("c3_sw", 32'(sw_en_o), 32'h08);

        // Switch 3 -> 5.
        req(1'b1, 5);
        chk("c5_break_sw", 32'(sw_en_o), 32'h00);
        measure(lat_sw, lat_pad);
        chk("c5_lat_sw", lat_sw, 5);
        chk("c5_lat_pad", lat_pad, 21);
        chk("c5_sw", 32'(sw_en_o), 32'h20);

        // Same source again: no-op.
        req(1'b1, 5);
        chk("same_ready", 32'(req_ready_o), 32'd1);
        chk("same_sw", 32'(sw_en_o), 32'h20);
        chk("same_pad", 32'(pad_ready_o), 32'd1);
        step();

        // Reset during MAKE.
        req(1'b1, 4);
        n = 0;
        while (!(busy_o && sw_en_o != '0) && n < 30) begin
            step();
            n++;
        end
        chk("reach_make", 32'(busy_o && sw_en_o != '0), 32'd1);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mk_rst_sw", 32'(sw_en_o), 32'd0);
        chk("mk_rst_busy", 32'(busy_o), 32'd0);
        chk("mk_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mk_rst_sel", 32'(sel_o), 32'd0);

        // Out-of-range connect while connected to 3.
        req(1'b1, 3);
        measure(lat_sw, lat_pad);
        chk("oor_pre_pad", lat_pad, 21);
        req(1'b1, 7);
`ifdef ANAIO_MUX_RANGE_CHK_EN
        chk("oor_err", 32'(err_o), 32'd1);
        chk("oor_sw", 32'(sw_en_o), 32'd0);
        repeat (BBM) step();
        chk("oor_idle_ready", 32'(req_ready_o), 32'd1);
        chk("oor_idle_sel", 32'(sel_o), 32'd0);
        step();
        chk("oor_err_sticky", 32'(err_o), 32'd1);
`else
        chk("oor_sw", 32'(sw_en_o), 32'h08);
        chk("oor_pad", 32'(pad_ready_o), 32'd1);
        repeat (BBM + 1) step();
        chk("oor_hold_sw", 32'(sw_en_o), 32'h08);
        chk("oor_hold_sel", 32'(sel_o), 32'd3);
`endif

        // Held request for 1 while connecting 2.
        req(1'b1, 2);
        req_valid_i = 1'b1; req_conn_i = 1'b1; req_sel_i = 3'd1;
        n = 0;
        while (!pad_ready_o && n < 40) begin
            step();
            n++;
        end
        chk("held_pad2", 32'(pad_ready_o), 32'd1);
        chk("held_sw2", 32'(sw_en_o), 32'h04);
        step();
        req_valid_i = 1'b0;
        chk("held_acc_sw", 32'(sw_en_o), 32'd0);
        chk("held_acc_sel", 32'(sel_o), 32'd1);
        n = 0;
        while (sw_en_o == '0 && n < 10) begin
            step();
            n++;
        end
        chk("held_break_len", n, BBM);
        chk("held_sw1", 32'(sw_en_o), 32'h02);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_i       = ($urandom_range(0, 99) == 0);
            req_valid_i = 1'($urandom_range(0, 1));
            req_conn_i  = ($urandom_range(0, 3) != 0);
            req_sel_i   = 3'($urandom_range(0, 7));
            step();
        end
        rst_i = 1'b0; req_valid_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
